serial_mag_comp: RTL and testbench

SERIAL_MAG_COMP -- requirements
Module: serial_mag_comp

---
 rtl/serial_mag_comp_if.sv | 24 ++
 rtl/serial_mag_comp.sv | 114 +++++++++++
 tb/tb_serial_mag_comp.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/serial_mag_comp_if.sv
// Operand/result bundle for the bit-serial magnitude comparator.
// The requester drives start/A/B; the comparator returns status and flags.
interface serial_mag_comp_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             Eq;
  logic             Le;
  logic             Gt;

  modport master (
    output start, A, B,
    input  busy, done, Eq, Le, Gt
  );

  modport slave (
    input  start, A, B,
    output busy, done, Eq, Le, Gt
  );
endinterface

// File: rtl/serial_mag_comp.sv
// Bit-serial unsigned magnitude comparator: walks the operands MSB first,
// one bit pair per cycle, and stops at the first differing pair.
module serial_mag_comp #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_mag_comp_if.slave   bus
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, a_sh_nxt;
  logic [WIDTH-1:0] b_sh, b_sh_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             eq_q, eq_nxt;
  logic             lt_q, lt_nxt;
  logic             gt_q, gt_nxt;

  // The operands are shifted left each equal cycle, so the bit under test
  // is always the top bit and no variable bit-select is needed.
  logic bit_a, bit_b, bit_eq, bit_lt, bit_gt;

  assign bit_a  = a_sh[WIDTH-1];
  assign bit_b  = b_sh[WIDTH-1];
  assign bit_eq = ~(bit_a ^ bit_b);
  assign bit_lt = ~bit_a & bit_b;
  assign bit_gt = bit_a & ~bit_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      idx   <= '0;
      eq_q  <= 1'b0;
      lt_q  <= 1'b0;
      gt_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      a_sh  <= a_sh_nxt;
      b_sh  <= b_sh_nxt;
      idx   <= idx_nxt;
      eq_q  <= eq_nxt;
      lt_q  <= lt_nxt;
      gt_q  <= gt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    a_sh_nxt  = a_sh;
    b_sh_nxt  = b_sh;
    idx_nxt   = idx;
    eq_nxt    = eq_q;
    lt_nxt    = lt_q;
    gt_nxt    = gt_q;

    case (state)
      IDLE: begin
        if (bus.start) begin
          a_sh_nxt  = bus.A;
          b_sh_nxt  = bus.B;
          idx_nxt   = IDX_TOP;
          eq_nxt    = 1'b0;
          lt_nxt    = 1'b0;
          gt_nxt    = 1'b0;
          state_nxt = COMPARE;
        end
      end

      COMPARE: begin
        if (bit_gt) begin
          gt_nxt    = 1'b1;
          state_nxt = DONE;
        end else if (bit_lt) begin
          lt_nxt    = 1'b1;
          state_nxt = DONE;
        end else if (bit_eq && (idx == '0)) begin
          eq_nxt    = 1'b1;
          state_nxt = DONE;
        end else begin
          // Index stops at zero; the branch above exits before it could wrap.
          idx_nxt  = idx - 1'b1;
          a_sh_nxt = {a_sh[WIDTH-2:0], 1'b0};
          b_sh_nxt = {b_sh[WIDTH-2:0], 1'b0};
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.busy = (state == COMPARE);
  assign bus.done = (state == DONE);
  assign bus.Eq   = eq_q;
  assign bus.Le   = lt_q;
  assign bus.Gt   = gt_q;

endmodule

// File: tb/tb_serial_mag_comp.sv
// Self-checking bench for serial_mag_comp: directed latency/flag cases, a
// mid-comparison reset, and randomized back-to-back traffic against a model.
module tb_serial_mag_comp;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  serial_mag_comp_if #(.WIDTH(W)) bus ();

  serial_mag_comp #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Packed view of all outputs: {busy, done, Eq, Le, Gt}.
  function automatic logic [31:0] outs();
    return {27'b0, bus.busy, bus.done, bus.Eq, bus.Le, bus.Gt};
  endfunction

  function automatic logic [31:0] pack(input logic busy, input logic done,
                                       input logic [2:0] res);
    return {27'b0, busy, done, res};
  endfunction

  // Cycles spent in COMPARE: position (1-based from MSB) of the first
  // differing bit, or W when the operands are equal.
  function automatic int ref_k(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] diff;
    diff = a ^ b;
    if (diff == '0) return W;
    for (int i = W - 1; i >= 0; i--)
      if (diff[i]) return W - i;
    return W;
  endfunction

  function automatic logic [2:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b);
    int ia, ib;
    ia = int'(a);
    ib = int'(b);
    return {ia == ib, ia < ib, ia > ib};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Launches one comparison from IDLE and checks every cycle through done,
  // the following IDLE cycle and an optional hold period.
  task automatic run_cmp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit keep_start, input int hold);
    int       k;
    logic [2:0] res;
    k   = ref_k(a, b);
    res = ref_res(a, b);
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    cycle();
    if (!keep_start) bus.start = 1'b0;
    for (int c = 1; c <= k; c++) begin
      chk({tag, "_compare"}, outs(), pack(1'b1, 1'b0, 3'b000));
      bus.A = W'($urandom);
      bus.B = W'($urandom);
      cycle();
    end
    chk({tag, "_done"}, outs(), pack(1'b0, 1'b1, res));
    cycle();
    chk({tag, "_idle"}, outs(), pack(1'b0, 1'b0, res));
    if (hold > 0) begin
      repeat (hold) cycle();
      chk({tag, "_hold"}, outs(), pack(1'b0, 1'b0, res));
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    #3;
    chk("reset_outs", outs(), 32'h0);
    #9;
    rst_n = 1'b1;
    cycle();
    chk("post_reset_idle", outs(), 32'h0);

    run_cmp("eq_a5", 8'hA5, 8'hA5, 1'b0, 0);
    run_cmp("gt_80_7f", 8'h80, 8'h7F, 1'b0, 0);
    run_cmp("lt_12_13", 8'h12, 8'h13, 1'b0, 5);

    // Re-pulsed start with a new A during COMPARE must be ignored.
    bus.A = 8'h40; bus.B = 8'h00; bus.start = 1'b1;
    cycle();
    chk("repulse_c1", outs(), pack(1'b1, 1'b0, 3'b000));
    bus.A = 8'h00; bus.start = 1'b1;
    cycle();
    chk("repulse_c2", outs(), pack(1'b1, 1'b0, 3'b000));
    bus.start = 1'b0;
    cycle();
    chk("repulse_done", outs(), pack(1'b0, 1'b1, 3'b001));
    cycle();
    chk("repulse_idle", outs(), pack(1'b0, 1'b0, 3'b001));

    // Reset in cycle 4 of a long comparison: everything clears at once.
    bus.A = 8'h01; bus.B = 8'h00; bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    repeat (3) cycle();
    chk("rst_pre", outs(), pack(1'b1, 1'b0, 3'b000));
    rst_n = 1'b0;
    #1;
    chk("rst_async", outs(), 32'h0);
    cycle();
    chk("rst_held", outs(), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_cmp("after_rst_eq", 8'h03, 8'h03, 1'b0, 0);

    // Back-to-back traffic with start held high.
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ W'(1 << $urandom_range(0, W - 1));
        default: rb = W'($urandom);
      endcase
      run_cmp("rand", ra, rb, 1'b1, 0);
    end
    bus.start = 1'b0;
    cycle();
    cycle();
    chk("final_idle_busy", {31'b0, bus.busy}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
